ddr4_sref_pr_sequencer: RTL and testbench
=========================================

Name: ddr4_sref_pr_sequencer

Overview:
- Static-region sequencer that parks all DDR4 channels of the dynamic region in self-refresh before partial reconfiguration, then sequences reset, calibration-skip and restore after the new partition loads.
- Drives the dynamic region's c0/c2/c3 app_sref_req, app_mem_init_skip, app_xsdb_select, app_restore_complete and sys_rst_ddr inputs.
- Consumes the dynamic region's app_sref_ack and init_calib_complete outputs.
- Host control is a simple pulse/status interface driven by the shell register block.

Parameters:
- N_CH, 3, number of DDR4 channels; index 0/1/2 maps to c0/c2/c3.
- CH_MASK, 3'b111, channels that participate; masked channels' outputs stay at reset value and their inputs are ignored.
- RST_CYCLES, 64, clock cycles sys_rst_ddr is held high after pr_done.
- XSDB_CYCLES, 256, clock cycles app_xsdb_select is held high in RESTORE.
- TIMEOUT_CYCLES, 2**20, watchdog limit for any wait state (used only with SREF_TIMEOUT_EN).

Ports:
- CLK_IN_125M  input  1  sole clock.
- AXI_RESET_N  input  1  asynchronous active-low reset.
- sr_enter_req  input  1  single-cycle pulse: enter self-refresh; ignored unless in IDLE.
- pr_done  input  1  single-cycle pulse: partial bitstream loaded; ignored unless in SREF_HOLD.
- sr_busy  output  1  high in any state other than IDLE and SREF_HOLD.
- sr_in_sref  output  1  high in SREF_HOLD; safe to reconfigure.
- sr_error  output  1  sticky error; cleared only by reset.
- sr_err_ch  output  N_CH  channel(s) that caused the timeout.
- app_sref_req  output  N_CH  to cX_ddr4_app_sref_req.
- app_sref_ack  input  N_CH  from cX_ddr4_app_sref_ack; asynchronous to this clock.
- init_calib_complete  input  N_CH  from cX_init_calib_complete; asynchronous.
- app_mem_init_skip  output  N_CH  to cX_ddr4_app_mem_init_skip.
- app_xsdb_select  output  N_CH  to cX_ddr4_app_xsdb_select.
- app_restore_complete  output  N_CH  to cX_ddr4_app_restore_complete.
- sys_rst_ddr  output  N_CH  to sys_rst_ddr_X; active high.

Behaviour:
- Inputs: app_sref_ack and init_calib_complete pass through 2-FF synchronizers (reset to 0). "Seen" below means the synchronized value.
- Reset values: all outputs 0; state IDLE; counters 0.
- SM state IDLE: on sr_enter_req, go to SREF_REQ.
- SM state SREF_REQ: app_sref_req=CH_MASK. When every masked ack is seen high, drop app_sref_req the next cycle and go to SREF_HOLD.
  - Acks arriving on different cycles are fine; an ack that drops before all acks are seen restarts the wait for that channel.
  - Minimum latency from sr_enter_req to sr_in_sref is 4 cycles with acks already high.
- SM state SREF_HOLD: sr_in_sref=1; app_mem_init_skip=CH_MASK, held from here until DONE. On pr_done, go to RESET.
- SM state RESET: sys_rst_ddr=CH_MASK for exactly RST_CYCLES cycles, then 0; go to RESTORE.
- SM state RESTORE: app_xsdb_select=CH_MASK for exactly XSDB_CYCLES cycles. The cycle after select drops, assert app_restore_complete=CH_MASK (held) and go to WAIT_CAL.
- SM state WAIT_CAL: wait until every masked init_calib_complete is seen high, then go to DONE.
- SM state DONE: one cycle; clear app_restore_complete and app_mem_init_skip; go to IDLE.
- Counter rules: counters are log2-sized, load on state entry and count down. RST_CYCLES and XSDB_CYCLES must be >=1.
- Request priority: pr_done in IDLE is ignored. sr_enter_req in any non-IDLE state is ignored.
- Async reset mid-sequence: immediate return to IDLE with all outputs 0. This deasserts init_skip, so the next MIG calibration is a full init; this is the intended recovery path.
- Masked channels: permanently treated as acked/calibrated.

Optional Feature:
- Macro: SREF_TIMEOUT_EN.
- Defined: a watchdog counter is cleared on entry to SREF_REQ and WAIT_CAL and counts in those states. When it reaches TIMEOUT_CYCLES:
  - sr_error is set.
  - sr_err_ch latches the masked channels not yet acked/calibrated.
  - All outputs are driven to 0 and the SM enters ERROR, which is terminal until reset.
- Undefined: no watchdog and no ERROR state; sr_error and sr_err_ch are tied 0; the SM waits indefinitely.

Decomposition:
- Package ddr4_sref_pkg: state enum (IDLE, SREF_REQ, SREF_HOLD, RESET, RESTORE, WAIT_CAL, DONE, ERROR) and default cycle constants.
- One natural sub-module: sref_sync2, a per-bit 2-FF synchronizer with async active-low reset, instantiated for N_CH acks and N_CH calib bits.

Test Plan:
- Nominal sequence:
  - Stimulus: sr_enter_req; acks rise 10 cycles later; pr_done; calib rises 500 cycles after restore_complete.
  - Required: app_sref_req high for 12-13 cycles; sr_in_sref high; sys_rst_ddr high exactly 64 cycles; xsdb_select high exactly 256 cycles; restore_complete held until calib is seen, +1 cycle; return to IDLE with skip=0.
- Staggered acks:
  - Stimulus: ch0 ack at +5, ch2 ack at +40.
  - Required: app_sref_req stays high until cycle ~42 and drops on all channels together.
- Ignored requests:
  - Stimulus: pr_done in IDLE; second sr_enter_req during RESTORE.
  - Required: no state change; sequence timing unaffected.
- Reset mid-operation:
  - Stimulus: AXI_RESET_N low for 3 cycles during RESTORE.
  - Required: all outputs 0 asynchronously; IDLE after release.
- CH_MASK=3'b101:
  - Stimulus: ch1 ack and calib never assert.
  - Required: sequence completes; ch1 outputs remain 0 throughout.
- SREF_TIMEOUT_EN with TIMEOUT_CYCLES=1000:
  - Stimulus: ch2 ack never asserts.
  - Required: at cycle 1000, sr_error=1, sr_err_ch=3'b100, app_sref_req=0; state stuck until reset.

Source files
------------

// File: rtl/ddr4_sref_pkg.sv
// Shared types and default timing for the DDR4 self-refresh PR sequencer.
// State encoding plus cycle constants used by ddr4_sref_pr_sequencer.
package ddr4_sref_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SREF_REQ,
    SREF_HOLD,
    RESET,
    RESTORE,
    WAIT_CAL,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned DEF_N_CH           = 3;
  localparam int unsigned DEF_RST_CYCLES     = 64;
  localparam int unsigned DEF_XSDB_CYCLES    = 256;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1 << 20;
  localparam int unsigned SYNC_STAGES        = 2;

  function automatic int unsigned cnt_w(
    input int unsigned a,
    input int unsigned b
  );
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > SYNC_STAGES) ? m : SYNC_STAGES;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sref_sync2.sv
// Single-bit two-flop synchronizer, async active-low reset to 0.
// Used for the MIG ack and calibration-complete status bits.
module sref_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ddr4_sref_pr_sequencer.sv
// Parks DDR4 channels in self-refresh around partial reconfiguration.
// Optional watchdog/ERROR state enabled by `define SREF_TIMEOUT_EN.
module ddr4_sref_pr_sequencer
  import ddr4_sref_pkg::*;
#(
  parameter int unsigned       N_CH           = DEF_N_CH,
  parameter logic [N_CH-1:0]   CH_MASK        = {N_CH{1'b1}},
  parameter int unsigned       RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned       XSDB_CYCLES    = DEF_XSDB_CYCLES,
  parameter int unsigned       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            CLK_IN_125M,
  input  logic            AXI_RESET_N,
  input  logic            sr_enter_req,
  input  logic            pr_done,
  output logic            sr_busy,
  output logic            sr_in_sref,
  output logic            sr_error,
  output logic [N_CH-1:0] sr_err_ch,
  output logic [N_CH-1:0] app_sref_req,
  input  logic [N_CH-1:0] app_sref_ack,
  input  logic [N_CH-1:0] init_calib_complete,
  output logic [N_CH-1:0] app_mem_init_skip,
  output logic [N_CH-1:0] app_xsdb_select,
  output logic [N_CH-1:0] app_restore_complete,
  output logic [N_CH-1:0] sys_rst_ddr
);

  localparam int unsigned CW = cnt_w(RST_CYCLES, XSDB_CYCLES);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_ld;
  logic [N_CH-1:0] w_ack_s;
  logic [N_CH-1:0] w_cal_s;
  logic            w_all_ack;
  logic            w_all_cal;
  logic            w_cnt_zero;
  logic            w_tmo;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    sref_sync2 u_ack (
      .i_clk   (CLK_IN_125M),
      .i_rst_n (AXI_RESET_N),
      .i_d     (app_sref_ack[i]),
      .o_q     (w_ack_s[i])
    );
    sref_sync2 u_cal (
      .i_clk   (CLK_IN_125M),
      .i_rst_n (AXI_RESET_N),
      .i_d     (init_calib_complete[i]),
      .o_q     (w_cal_s[i])
    );
  end

  assign w_all_ack  = &(w_ack_s | ~CH_MASK);
  assign w_all_cal  = &(w_cal_s | ~CH_MASK);
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge CLK_IN_125M or negedge AXI_RESET_N) begin
    if (!AXI_RESET_N) r_state <= IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (sr_enter_req) w_next = SREF_REQ;
      SREF_REQ: begin
        if (w_cnt_zero && w_all_ack) w_next = SREF_HOLD;
        else if (w_tmo)              w_next = ERROR;
      end
      SREF_HOLD: if (pr_done)    w_next = RESET;
      RESET:     if (w_cnt_zero) w_next = RESTORE;
      RESTORE:   if (w_cnt_zero) w_next = WAIT_CAL;
      WAIT_CAL: begin
        if (w_all_cal)  w_next = DONE;
        else if (w_tmo) w_next = ERROR;
      end
      DONE:      w_next = IDLE;
`ifdef SREF_TIMEOUT_EN
      ERROR:     w_next = ERROR;
`else
      ERROR:     w_next = IDLE;
`endif
      default:   w_next = IDLE;
    endcase
  end

  // SREF_REQ holds off for the sync depth so stale acks cannot satisfy it
  always_comb begin
    w_cnt_ld = '0;
    unique case (w_next)
      SREF_REQ: w_cnt_ld = CW'(SYNC_STAGES);
      RESET:    w_cnt_ld = CW'(RST_CYCLES - 1);
      RESTORE:  w_cnt_ld = CW'(XSDB_CYCLES - 1);
      default:  w_cnt_ld = '0;
    endcase
  end

  always_ff @(posedge CLK_IN_125M or negedge AXI_RESET_N) begin
    if (!AXI_RESET_N)           r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= w_cnt_ld;
    else if (!w_cnt_zero)       r_cnt <= r_cnt - 1'b1;
  end

  always_comb begin
    sr_busy              = 1'b0;
    sr_in_sref           = 1'b0;
    app_sref_req         = '0;
    app_mem_init_skip    = '0;
    app_xsdb_select      = '0;
    app_restore_complete = '0;
    sys_rst_ddr          = '0;
    unique case (r_state)
      IDLE: ;
      SREF_REQ: begin
        sr_busy      = 1'b1;
        app_sref_req = CH_MASK;
      end
      SREF_HOLD: begin
        sr_in_sref        = 1'b1;
        app_mem_init_skip = CH_MASK;
      end
      RESET: begin
        sr_busy           = 1'b1;
        app_mem_init_skip = CH_MASK;
        sys_rst_ddr       = CH_MASK;
      end
      RESTORE: begin
        sr_busy           = 1'b1;
        app_mem_init_skip = CH_MASK;
        app_xsdb_select   = CH_MASK;
      end
      WAIT_CAL: begin
        sr_busy              = 1'b1;
        app_mem_init_skip    = CH_MASK;
        app_restore_complete = CH_MASK;
      end
      DONE:  sr_busy = 1'b1;
      ERROR: sr_busy = 1'b1;
      default: ;
    endcase
  end

`ifdef SREF_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0]   r_wdog;
  logic            r_err;
  logic [N_CH-1:0] r_err_ch;

  assign w_tmo = (r_wdog == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK_IN_125M or negedge AXI_RESET_N) begin
    if (!AXI_RESET_N)
      r_wdog <= '0;
    else if (w_next != r_state)
      r_wdog <= '0;
    else if (r_state == SREF_REQ || r_state == WAIT_CAL)
      r_wdog <= r_wdog + 1'b1;
  end

  always_ff @(posedge CLK_IN_125M or negedge AXI_RESET_N) begin
    if (!AXI_RESET_N) begin
      r_err    <= 1'b0;
      r_err_ch <= '0;
    end else if (w_next == ERROR && r_state != ERROR) begin
      r_err    <= 1'b1;
      r_err_ch <= (r_state == SREF_REQ) ? (CH_MASK & ~w_ack_s)
                                        : (CH_MASK & ~w_cal_s);
    end
  end

  assign sr_error  = r_err;
  assign sr_err_ch = r_err_ch;
`else
  logic w_unused_tmo;

  assign w_tmo        = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign sr_error     = 1'b0;
  assign sr_err_ch    = '0;
`endif

endmodule

// File: tb/tb_ddr4_sref_pr_sequencer.sv
// Directed bench for ddr4_sref_pr_sequencer: full-mask and 3'b101 instances.
// Timeout scenario runs only when SREF_TIMEOUT_EN is defined.
module tb_ddr4_sref_pr_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic       a_enter, a_pr, a_busy, a_in, a_err;
  logic [2:0] a_ack, a_cal, a_errch, a_req, a_skip, a_xsdb, a_restore, a_rst;
  logic       b_enter, b_pr, b_busy, b_in, b_err;
  logic [2:0] b_ack, b_cal, b_errch, b_req, b_skip, b_xsdb, b_restore, b_rst;

  int n_chk = 0;
  int n_fail = 0;

  ddr4_sref_pr_sequencer u_a (
    .CLK_IN_125M          (clk),
    .AXI_RESET_N          (rst_n),
    .sr_enter_req         (a_enter),
    .pr_done              (a_pr),
    .sr_busy              (a_busy),
    .sr_in_sref           (a_in),
    .sr_error             (a_err),
    .sr_err_ch            (a_errch),
    .app_sref_req         (a_req),
    .app_sref_ack         (a_ack),
    .init_calib_complete  (a_cal),
    .app_mem_init_skip    (a_skip),
    .app_xsdb_select      (a_xsdb),
    .app_restore_complete (a_restore),
    .sys_rst_ddr          (a_rst)
  );

  ddr4_sref_pr_sequencer #(
    .CH_MASK        (3'b101),
    .TIMEOUT_CYCLES (1000)
  ) u_b (
    .CLK_IN_125M          (clk),
    .AXI_RESET_N          (rst_n),
    .sr_enter_req         (b_enter),
    .pr_done              (b_pr),
    .sr_busy              (b_busy),
    .sr_in_sref           (b_in),
    .sr_error             (b_err),
    .sr_err_ch            (b_errch),
    .app_sref_req         (b_req),
    .app_sref_ack         (b_ack),
    .init_calib_complete  (b_cal),
    .app_mem_init_skip    (b_skip),
    .app_xsdb_select      (b_xsdb),
    .app_restore_complete (b_restore),
    .sys_rst_ddr          (b_rst)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    {a_enter, a_pr, a_ack, a_cal} = '0;
    {b_enter, b_pr, b_ack, b_cal} = '0;
    repeat (3) tick;
    n_chk++;
    if ({a_busy, a_in, a_err, a_errch, a_req, a_skip, a_xsdb, a_restore, a_rst} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_outputs: got %b want all 0",
        {a_busy, a_in, a_err, a_errch, a_req, a_skip, a_xsdb, a_restore, a_rst});
    end
    n_chk++;
    if ({b_busy, b_in, b_err, b_errch, b_req, b_skip, b_xsdb, b_restore, b_rst} !== '0) begin
      n_fail++;
      $display("FAIL reset_b_outputs: got %b want all 0",
        {b_busy, b_in, b_err, b_errch, b_req, b_skip, b_xsdb, b_restore, b_rst});
    end
    rst_n = 1'b1;
    repeat (2) tick;
    n_chk++;
    if ({a_busy, a_in, a_req} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b want 00000", {a_busy, a_in, a_req});
    end
  endtask

  task automatic test_nominal;
    int hi;
    int n;
    a_enter = 1'b1;
    tick;
    a_enter = 1'b0;
    hi = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 10) a_ack = 3'b111;
      if (a_req === 3'b111) hi++;
      tick;
    end
    n_chk++;
    if (hi != 12) begin
      n_fail++;
      $display("FAIL nominal_sref_req_len: got %0d cycles want 12", hi);
    end
    n_chk++;
    if ({a_in, a_busy, a_req, a_skip} !== 8'b10_000_111) begin
      n_fail++;
      $display("FAIL nominal_hold: got %b want 10000111", {a_in, a_busy, a_req, a_skip});
    end
    a_pr = 1'b1;
    tick;
    a_pr = 1'b0;
    n = 0;
    while (a_rst === 3'b111 && n < 1000) begin n++; tick; end
    n_chk++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL nominal_rst_len: got %0d cycles want 64", n);
    end
    n_chk++;
    if ({a_rst, a_xsdb, a_skip} !== 9'b000_111_111) begin
      n_fail++;
      $display("FAIL nominal_restore_entry: got %b want 000111111", {a_rst, a_xsdb, a_skip});
    end
    n = 0;
    while (a_xsdb === 3'b111 && n < 1000) begin n++; tick; end
    n_chk++;
    if (n != 256) begin
      n_fail++;
      $display("FAIL nominal_xsdb_len: got %0d cycles want 256", n);
    end
    n_chk++;
    if ({a_xsdb, a_restore} !== 6'b000_111) begin
      n_fail++;
      $display("FAIL nominal_restore_cmpl: got %b want 000111", {a_xsdb, a_restore});
    end
    n = 0;
    while (a_restore === 3'b111 && n < 2000) begin
      if (n == 500) a_cal = 3'b111;
      n++;
      tick;
    end
    n_chk++;
    if (n != 503) begin
      n_fail++;
      $display("FAIL nominal_restore_len: got %0d cycles want 503", n);
    end
    n_chk++;
    if ({a_busy, a_skip, a_restore} !== 7'b1_000_000) begin
      n_fail++;
      $display("FAIL nominal_done: got %b want 1000000", {a_busy, a_skip, a_restore});
    end
    tick;
    n_chk++;
    if ({a_busy, a_in, a_skip} !== 5'b0) begin
      n_fail++;
      $display("FAIL nominal_idle: got %b want 00000", {a_busy, a_in, a_skip});
    end
    a_ack = '0;
    a_cal = '0;
    repeat (4) tick;
  endtask

  task automatic test_staggered;
    int hi;
    int odd;
    int n;
    a_enter = 1'b1;
    tick;
    a_enter = 1'b0;
    hi = 0;
    odd = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5)  a_ack[0] = 1'b1;
      if (c == 20) a_ack[1] = 1'b1;
      if (c == 40) a_ack[2] = 1'b1;
      if (a_req === 3'b111) hi++;
      else if (a_req !== 3'b000) odd++;
      tick;
    end
    n_chk++;
    if (hi != 42 || odd != 0) begin
      n_fail++;
      $display("FAIL stagger_req: got %0d high/%0d partial want 42/0", hi, odd);
    end
    n_chk++;
    if (a_in !== 1'b1) begin
      n_fail++;
      $display("FAIL stagger_in_sref: got %b want 1", a_in);
    end
    a_cal = 3'b111;
    a_pr = 1'b1;
    tick;
    a_pr = 1'b0;
    n = 0;
    while (a_busy && n < 2000) begin n++; tick; end
    n_chk++;
    if (a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stagger_complete: busy got %b want 0", a_busy);
    end
    a_ack = '0;
    a_cal = '0;
    repeat (4) tick;
  endtask

  task automatic test_ignored;
    int n;
    a_pr = 1'b1;
    tick;
    a_pr = 1'b0;
    repeat (3) tick;
    n_chk++;
    if ({a_busy, a_in, a_rst} !== 5'b0) begin
      n_fail++;
      $display("FAIL ignore_pr_idle: got %b want 00000", {a_busy, a_in, a_rst});
    end
    a_ack = 3'b111;
    repeat (4) tick;
    a_enter = 1'b1;
    tick;
    a_enter = 1'b0;
    repeat (2) tick;
    n_chk++;
    if ({a_in, a_req} !== 4'b0111) begin
      n_fail++;
      $display("FAIL latency_cycle3: got %b want 0111", {a_in, a_req});
    end
    tick;
    n_chk++;
    if ({a_in, a_req} !== 4'b1000) begin
      n_fail++;
      $display("FAIL latency_cycle4: got %b want 1000", {a_in, a_req});
    end
    a_pr = 1'b1;
    tick;
    a_pr = 1'b0;
    n = 0;
    while (a_rst === 3'b111 && n < 1000) begin n++; tick; end
    n_chk++;
    if (n != 64) begin
      n_fail++;
      $display("FAIL ignore_rst_len: got %0d want 64", n);
    end
    n = 0;
    while (a_xsdb === 3'b111 && n < 1000) begin
      a_enter = (n == 100);
      n++;
      tick;
    end
    a_enter = 1'b0;
    n_chk++;
    if (n != 256) begin
      n_fail++;
      $display("FAIL ignore_xsdb_len: got %0d want 256", n);
    end
    a_cal = 3'b111;
    n = 0;
    while (a_busy && n < 100) begin n++; tick; end
    repeat (5) tick;
    n_chk++;
    if ({a_busy, a_in, a_req} !== 5'b0) begin
      n_fail++;
      $display("FAIL ignore_enter_restore: got %b want 00000", {a_busy, a_in, a_req});
    end
    a_ack = '0;
    a_cal = '0;
    repeat (4) tick;
  endtask

  task automatic test_reset_mid;
    int n;
    a_ack = 3'b111;
    repeat (4) tick;
    a_enter = 1'b1;
    tick;
    a_enter = 1'b0;
    repeat (4) tick;
    a_pr = 1'b1;
    tick;
    a_pr = 1'b0;
    n = 0;
    while (a_xsdb !== 3'b111 && n < 200) begin n++; tick; end
    repeat (10) tick;
    n_chk++;
    if ({a_xsdb, a_skip} !== 6'b111_111) begin
      n_fail++;
      $display("FAIL midreset_in_restore: got %b want 111111", {a_xsdb, a_skip});
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_busy, a_in, a_req, a_skip, a_xsdb, a_restore, a_rst} !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: got %b want all 0",
        {a_busy, a_in, a_req, a_skip, a_xsdb, a_restore, a_rst});
    end
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (2) tick;
    n_chk++;
    if ({a_busy, a_in, a_skip, a_xsdb} !== 8'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: got %b want all 0", {a_busy, a_in, a_skip, a_xsdb});
    end
    a_ack = '0;
    repeat (4) tick;
  endtask

  task automatic test_mask;
    int n;
    logic ch1;
    logic saw_rst;
    ch1 = 1'b0;
    saw_rst = 1'b0;
    b_enter = 1'b1;
    tick;
    b_enter = 1'b0;
    n_chk++;
    if (b_req !== 3'b101) begin
      n_fail++;
      $display("FAIL mask_req: got %b want 101", b_req);
    end
    n = 0;
    while (!b_in && n < 100) begin
      if (n == 9) b_ack = 3'b101;
      ch1 |= b_req[1] | b_skip[1] | b_xsdb[1] | b_restore[1] | b_rst[1];
      n++;
      tick;
    end
    n_chk++;
    if (b_in !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_in_sref: got %b want 1", b_in);
    end
    b_cal = 3'b101;
    b_pr = 1'b1;
    tick;
    b_pr = 1'b0;
    n = 0;
    while (b_busy && n < 2000) begin
      ch1 |= b_req[1] | b_skip[1] | b_xsdb[1] | b_restore[1] | b_rst[1];
      saw_rst |= (b_rst === 3'b101);
      n++;
      tick;
    end
    n_chk++;
    if ({b_busy, b_skip, saw_rst} !== 5'b0_000_1) begin
      n_fail++;
      $display("FAIL mask_complete: got %b want 00001", {b_busy, b_skip, saw_rst});
    end
    n_chk++;
    if (ch1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_ch1_quiet: got %b want 0", ch1);
    end
    n_chk++;
    if ({b_err, b_errch} !== 4'b0) begin
      n_fail++;
      $display("FAIL mask_no_error: got %b want 0000", {b_err, b_errch});
    end
    b_ack = '0;
    b_cal = '0;
    repeat (4) tick;
  endtask

`ifdef SREF_TIMEOUT_EN
  task automatic test_timeout;
    b_ack = 3'b001;
    repeat (4) tick;
    b_enter = 1'b1;
    tick;
    b_enter = 1'b0;
    repeat (999) tick;
    n_chk++;
    if ({b_err, b_req} !== 4'b0101) begin
      n_fail++;
      $display("FAIL tmo_before: got %b want 0101", {b_err, b_req});
    end
    tick;
    n_chk++;
    if ({b_err, b_errch, b_req, b_skip} !== 10'b1_100_000_000) begin
      n_fail++;
      $display("FAIL tmo_fire: got %b want 1100000000", {b_err, b_errch, b_req, b_skip});
    end
    b_pr = 1'b1;
    b_enter = 1'b1;
    tick;
    b_pr = 1'b0;
    b_enter = 1'b0;
    b_ack = 3'b101;
    repeat (5) tick;
    n_chk++;
    if ({b_err, b_busy, b_in, b_req} !== 6'b110_000) begin
      n_fail++;
      $display("FAIL tmo_stuck: got %b want 110000", {b_err, b_busy, b_in, b_req});
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    n_chk++;
    if ({b_err, b_errch, b_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL tmo_reset_clear: got %b want 00000", {b_err, b_errch, b_busy});
    end
    b_ack = '0;
  endtask
`endif

  initial begin
    #10000000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_nominal;
    test_staggered;
    test_ignored;
    test_reset_mid;
    test_mask;
`ifdef SREF_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
